// File: rtl/range_frame_packer_if.sv
// rtl/range_frame_packer_if.sv - sample-in / burst-out bus of the range frame packer
interface range_frame_packer_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_go;
  logic             out_finish;
  logic             frame_drop;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, out_data, out_go, out_finish, frame_drop
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, out_data, out_go, out_finish, frame_drop
  );
endinterface

// File: rtl/range_frame_packer.sv
// rtl/range_frame_packer.sv - buffers a frame and replays it as a gapless go..finish burst
// Option macro: RANGE_PACKER_SINGLE_DUP_EN (1-sample frames replay twice instead of dropping).
module range_frame_packer #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input logic clock,
  input logic reset,
  range_frame_packer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);

`ifdef RANGE_PACKER_SINGLE_DUP_EN
  localparam bit SINGLE_DUP = 1'b1;
`else
  localparam bit SINGLE_DUP = 1'b0;
`endif

  typedef enum logic [1:0] {FILL, DISCARD, DRAIN} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] buffer [DEPTH];
  logic [AW-1:0]    wr_cnt;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    last_idx;
  logic             dup;
  logic             accept;
  logic [AW-1:0]    rd_idx;

  assign bus.in_ready = (state != DRAIN);
  assign accept       = bus.in_valid && bus.in_ready;
  // A duplicated single sample re-reads slot 0 instead of advancing.
  assign rd_idx       = dup ? '0 : rd_ptr;

  always_ff @(posedge clock) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if (accept && bus.in_last) begin
          if (wr_cnt != '0 || SINGLE_DUP) state_next = DRAIN;
        end else if (accept && wr_cnt == LAST_SLOT) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (accept && bus.in_last) state_next = FILL;
      end
      DRAIN: begin
        if (bus.out_finish) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (state == FILL && accept) buffer[wr_cnt] <= bus.in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_cnt         <= '0;
      rd_ptr         <= '0;
      last_idx       <= '0;
      dup            <= 1'b0;
      bus.out_data   <= '0;
      bus.out_go     <= 1'b0;
      bus.out_finish <= 1'b0;
      bus.frame_drop <= 1'b0;
    end else begin
      bus.frame_drop <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            if (bus.in_last) begin
              wr_cnt <= '0;
              if (wr_cnt == '0 && !SINGLE_DUP) begin
                bus.frame_drop <= 1'b1;
              end else begin
                // Slot 0 is being written this edge for a 1-sample frame, so forward it.
                bus.out_data   <= (wr_cnt == '0) ? bus.in_data : buffer[0];
                bus.out_go     <= 1'b1;
                bus.out_finish <= 1'b0;
                rd_ptr         <= AW'(1);
                dup            <= (wr_cnt == '0);
                last_idx       <= (wr_cnt == '0) ? AW'(1) : wr_cnt;
              end
            end else if (wr_cnt == LAST_SLOT) begin
              wr_cnt <= '0;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        DISCARD: begin
          if (accept && bus.in_last) bus.frame_drop <= 1'b1;
        end
        DRAIN: begin
          if (bus.out_finish) begin
            bus.out_data   <= '0;
            bus.out_go     <= 1'b0;
            bus.out_finish <= 1'b0;
            dup            <= 1'b0;
            wr_cnt         <= '0;
          end else begin
            bus.out_data   <= buffer[rd_idx];
            bus.out_go     <= 1'b0;
            bus.out_finish <= (rd_ptr == last_idx);
            rd_ptr         <= rd_ptr + 1'b1;
          end
        end
        default: begin
          bus.out_data   <= '0;
          bus.out_go     <= 1'b0;
          bus.out_finish <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/range_frame_packer.md
RANGE_FRAME_PACKER -- requirements
Module: range_frame_packer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, giving the sample width.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the maximum frame length in samples; DEPTH SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port clock, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port in_data, input, WIDTH bits, the upstream sample.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning in_data is valid this cycle.
REQ-007 The block SHALL have port in_last, input, 1 bit, meaning the current valid sample ends the frame.
REQ-008 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a sample this cycle.
REQ-009 The block SHALL have port out_data, output, WIDTH bits, the sample presented to the downstream range finder's data_in.
REQ-010 The block SHALL have port out_go, output, 1 bit, asserted with the first sample of a burst.
REQ-011 The block SHALL have port out_finish, output, 1 bit, asserted with the last sample of a burst.
REQ-012 The block SHALL have port frame_drop, output, 1 bit, a one-cycle pulse when a frame is discarded.

Function
REQ-013 A sample SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-014 The state machine SHALL have three states: FILL, DISCARD and DRAIN.
REQ-015 In FILL, in_ready SHALL be 1; each accepted sample SHALL be written to buffer[wr_cnt] and wr_cnt SHALL increment.
REQ-016 In FILL, an accepted sample with in_last=1 SHALL move the state to DRAIN on the next cycle, with frame length n = wr_cnt+1.
REQ-017 In FILL, accepting the DEPTH-th sample with in_last=0 SHALL move the state to DISCARD and SHALL discard the buffered contents.
REQ-018 In DISCARD, in_ready SHALL be 1 and accepted samples SHALL be discarded; an accepted sample with in_last=1 SHALL pulse frame_drop the next cycle and return the state to FILL with wr_cnt=0.
REQ-019 In DRAIN, in_ready SHALL be 0.
REQ-020 In DRAIN, the block SHALL present buffer[0..n-1] on out_data on n consecutive cycles with no gaps, because the downstream stage samples every cycle between go and finish.
REQ-021 In DRAIN, out_go SHALL be 1 only with buffer[0], and out_finish SHALL be 1 only with buffer[n-1].
REQ-022 The first DRAIN output SHALL appear in the cycle after in_last is accepted, giving a latency of 1.
REQ-023 On the cycle after out_finish, the state SHALL be FILL with wr_cnt=0 and in_ready=1.
REQ-024 out_go and out_finish SHALL never be high in the same cycle.
REQ-025 Outside DRAIN, out_data, out_go and out_finish SHALL be 0.
REQ-026 All outputs except in_ready SHALL be registered; in_ready SHALL be decoded from the state only.
REQ-027 in_last with in_valid=0 SHALL be ignored.

Reset
REQ-028 While reset=1 at a clock edge, the state SHALL become FILL, wr_cnt and the read pointer SHALL become 0, out_data, out_go, out_finish and frame_drop SHALL become 0, and in_ready SHALL read 1 from the following cycle.
REQ-029 A reset mid-DRAIN or mid-DISCARD SHALL abandon the frame without asserting out_finish or frame_drop.
REQ-030 Buffer contents SHALL not require reset.

Configuration
REQ-031 Macro RANGE_PACKER_SINGLE_DUP_EN SHALL control handling of single-sample frames (n=1).
REQ-032 With RANGE_PACKER_SINGLE_DUP_EN defined, a 1-sample frame SHALL drain over 2 cycles: buffer[0] with out_go, then buffer[0] with out_finish, so that downstream range = 0.
REQ-033 Without RANGE_PACKER_SINGLE_DUP_EN, a 1-sample frame SHALL not drain; frame_drop SHALL pulse the next cycle and the state SHALL stay FILL.

Verification
REQ-034 Frame 5,9,2,7 (last on 7) SHALL produce out_data 5,9,2,7 on 4 consecutive cycles starting 1 cycle after the last is accepted, with go on 5 and finish on 7; downstream range = 7.
REQ-035 Same frame with in_valid gaps between samples SHALL produce an identical gapless output burst, with in_ready=0 for all 4 drain cycles.
REQ-036 With DEPTH=16, 16 samples without last then 3 more with last on the 19th SHALL give no go or finish, in_ready held 1, and one frame_drop pulse the cycle after the 19th sample.
REQ-037 A 1-sample frame of value 300 SHALL give 300 with go then 300 with finish when the macro is defined, and a single frame_drop pulse with no go when it is undefined.
REQ-038 A 16-sample frame 0..15 with in_last on 15 SHALL drain all 16 samples in order, with finish on 15.
REQ-039 Reset asserted on the 2nd drain cycle of a 4-sample frame SHALL give go=0 and finish=0 thereafter, in_ready=1, and the next frame 1,2 SHALL drain correctly.
